interrupt_controller: RTL

- Prioritised 8-line interrupt controller; produces `int_pending` for the microcode sequencer's condition mux.
- Accepts an acknowledge pulse from the microcode trap routine, supplies an 8-bit vector, tracks in-service levels for nesting and retires them on end-of-interrupt (EOI).
- Register writes come from `z_bus` under microcode control strobes.

---
 rtl/interrupt_controller.sv | 75 +++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: prioritised 8-line interrupt controller with nesting, masking and EOI
// Ports: clk, arst (async active-low); irq[7:0] async edge requests, irq[0] highest;
//        int_enable gates int_pending; z_bus + mask_wr/pend_clr_wr write mask / clear pending;
//        int_ack latches int_vector/int_spurious and moves winner to in_service; eoi retires
//        the highest-priority in-service level; int_mask, pending_bits, in_service are state views.
module interrupt_controller #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] VEC_BASE    = 8'h20
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] irq,
    input  logic       int_enable,
    input  logic [7:0] z_bus,
    input  logic       mask_wr,
    input  logic       pend_clr_wr,
    input  logic       int_ack,
    input  logic       eoi,
    output logic       int_pending,
    output logic [7:0] int_vector,
    output logic       int_spurious,
    output logic [7:0] int_mask,
    output logic [7:0] pending_bits,
    output logic [7:0] in_service
);
    logic [SYNC_STAGES-1:0][7:0] r_sync;
    logic [7:0] r_prev, r_mask, r_pend, r_isr, r_vec;
    logic       r_spur;
    logic [7:0] w_rise, w_isr_low, w_thresh, w_elig, w_win, w_pend_nxt, w_isr_nxt;
    logic [2:0] w_idx;
    logic       w_any;
    assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_prev;
    // lowest set in-service bit; everything below it is the allowed threshold window
    assign w_isr_low = r_isr & (~r_isr + 8'd1);
    assign w_thresh  = (r_isr == 8'h00) ? 8'hFF : w_isr_low - 8'd1;
    assign w_elig    = r_pend & r_mask & w_thresh;
    assign w_win     = w_elig & (~w_elig + 8'd1);
    assign w_any     = |w_elig;
    always_comb begin
        w_idx = 3'd7;
        for (int i = 7; i >= 0; i--)
            if (w_elig[i]) w_idx = i[2:0];
    end
    // new edges win over both the software clear and the ack clear
    assign w_pend_nxt = (r_pend & ~(pend_clr_wr ? z_bus : 8'h00) & ~(int_ack ? w_win : 8'h00)) | w_rise;
    // ack set wins over eoi clear when both target the same level
    assign w_isr_nxt  = (r_isr & ~(eoi ? w_isr_low : 8'h00)) | (int_ack ? w_win : 8'h00);
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_sync <= '0;
            r_prev <= 8'h00;
            r_mask <= 8'h00;
            r_pend <= 8'h00;
            r_isr  <= 8'h00;
            r_vec  <= VEC_BASE;
            r_spur <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irq};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_pend <= w_pend_nxt;
            r_isr  <= w_isr_nxt;
            if (mask_wr) r_mask <= z_bus;
            if (int_ack) begin
                r_vec  <= {VEC_BASE[7:3], w_idx};
                r_spur <= ~w_any;
            end
        end
    end
    assign int_pending  = int_enable & w_any;
    assign int_vector   = r_vec;
    assign int_spurious = r_spur;
    assign int_mask     = r_mask;
    assign pending_bits = r_pend;
    assign in_service   = r_isr;
endmodule
